hic_scan_sequencer: RTL

Measurement scan controller for the home inventory chip. It turns the CTRL/IRQ_EN control plane (enable, start, interrupt enables) into a sequenced scan over up to N_CH sensor channels. For each enabled channel it selects the channel, waits a programmable settle time, handshakes one conversion with the ADC front-end, and writes the result to the result store. It returns an 8-bit status byte for the STATUS register and drives one level interrupt line.

---
 rtl/hic_pkg.sv | 31 +++
 rtl/hic_prio_pick.sv | 30 +++
 rtl/hic_scan_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/hic_pkg.sv
// hic_pkg: shared definitions for the home inventory chip scan sequencer.
//   state_t          - scan FSM state encoding
//   IRQ_*            - bit positions of the pending / irq_en / irq_clr vectors
//   ST_*             - field positions inside the 8-bit STATUS byte
//   ch_width()       - channel index width for a given channel count
package hic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_CONVERT,
        S_STORE,
        S_DONE
    } state_t;

    localparam int IRQ_DONE    = 0;
    localparam int IRQ_TIMEOUT = 1;
    localparam int IRQ_OVERRUN = 2;
    localparam int N_IRQ       = 3;

    localparam int ST_BUSY     = 0;
    localparam int ST_PEND_LSB = 1;
    localparam int ST_LAST_LSB = 4;
    localparam int ST_LAST_W   = 4;

    function automatic int ch_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hic_prio_pick.sv
// hic_prio_pick: combinational lowest-set-bit finder with a start index.
//   mask  - candidate channel bitmap
//   ptr   - first index to consider (may equal N_CH, meaning "none left")
//   found - a set bit exists at an index >= ptr
//   idx   - index of the lowest such bit (0 when not found)
module hic_prio_pick
    import hic_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int CH_W  = ch_width(N_CH),
    localparam int PTR_W = CH_W + 1
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [CH_W-1:0]  idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && mask[i] && (i >= 32'(ptr))) begin
                found = 1'b1;
                idx   = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/hic_scan_sequencer.sv
// hic_scan_sequencer: measurement scan controller.
// Walks the channels enabled in ch_mask in ascending order; for each one it
// selects the channel, waits settle_cycles+1 cycles, handshakes one ADC
// conversion (with timeout) and emits a one-cycle result write.
//   wb_clk_i, wb_rst_i          - clock, synchronous active-high reset
//   ctrl_enable, ctrl_start     - engine enable, start request (rising edge)
//   ch_mask, settle_cycles      - scan set and settle time, sampled per channel
//   irq_en, irq_clr             - interrupt enables, write-1-to-clear pulses
//   adc_ch, adc_req             - channel select and conversion request
//   adc_ack, adc_data           - conversion complete and result
//   res_we, res_idx, res_data   - result store write port
//   busy, status, irq           - scan active, STATUS byte, level interrupt
module hic_scan_sequencer
    import hic_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int DATA_W   = 24,
    parameter  int SETTLE_W = 16,
    parameter  int TIMEOUT  = 1024,
    localparam int CH_W     = ch_width(N_CH)
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                ctrl_enable,
    input  logic                ctrl_start,
    input  logic [N_CH-1:0]     ch_mask,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [N_IRQ-1:0]    irq_en,
    input  logic [N_IRQ-1:0]    irq_clr,
    output logic [CH_W-1:0]     adc_ch,
    output logic                adc_req,
    input  logic                adc_ack,
    input  logic [DATA_W-1:0]   adc_data,
    output logic                res_we,
    output logic [CH_W-1:0]     res_idx,
    output logic [DATA_W-1:0]   res_data,
    output logic                busy,
    output logic [7:0]          status,
    output logic                irq
);

    localparam int PTR_W = CH_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    state_t              state;
    logic                start_q;
    logic [PTR_W-1:0]    ch_ptr;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic [N_IRQ-1:0]    pending;
    logic [N_IRQ-1:0]    pend_set;
    logic [CH_W-1:0]     last_ch;
    logic                pick_found;
    logic [CH_W-1:0]     pick_idx;
    logic                start_rise;
    logic                abort;
    logic                to_expire;

    hic_prio_pick #(
        .N_CH (N_CH)
    ) u_pick (
        .mask  (ch_mask),
        .ptr   (ch_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Pending-bit set sources; an abort (enable low) suppresses done/timeout.
    always_comb begin
        start_rise = ctrl_start & ~start_q;
        abort      = (state != S_IDLE) && !ctrl_enable;
        to_expire  = (state == S_CONVERT) && !adc_ack &&
                     (to_cnt == TO_W'(TIMEOUT - 1));
        pend_set              = '0;
        pend_set[IRQ_DONE]    = (state == S_DONE) && ctrl_enable;
        pend_set[IRQ_TIMEOUT] = to_expire && ctrl_enable;
        pend_set[IRQ_OVERRUN] = (state != S_IDLE) && start_rise;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            ch_ptr     <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
            pending    <= '0;
            last_ch    <= '0;
            adc_ch     <= '0;
            adc_req    <= 1'b0;
            res_we     <= 1'b0;
            res_idx    <= '0;
            res_data   <= '0;
            busy       <= 1'b0;
            irq        <= 1'b0;
        end else begin
            start_q <= ctrl_start;
            // Set wins over a simultaneous clear.
            pending <= (pending & ~irq_clr) | pend_set;
            irq     <= |(pending & irq_en);
            res_we  <= 1'b0;

            if (abort) begin
                state   <= S_IDLE;
                adc_req <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (ctrl_enable && start_rise) begin
                            ch_ptr <= '0;
                            state  <= S_SELECT;
                            busy   <= 1'b1;
                        end
                    end
                    S_SELECT: begin
                        if (pick_found) begin
                            adc_ch     <= pick_idx;
                            settle_cnt <= settle_cycles;
                            state      <= S_SETTLE;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt == '0) begin
                            state   <= S_CONVERT;
                            adc_req <= 1'b1;
                            to_cnt  <= '0;
                        end else begin
                            settle_cnt <= settle_cnt - SETTLE_W'(1);
                        end
                    end
                    S_CONVERT: begin
                        // Write strobe is raised on entry so it is high
                        // during the STORE cycle itself.
                        if (adc_ack) begin
                            res_data <= adc_data;
                            adc_req  <= 1'b0;
                            res_we   <= 1'b1;
                            res_idx  <= adc_ch;
                            state    <= S_STORE;
                        end else if (to_expire) begin
                            res_data <= '1;
                            adc_req  <= 1'b0;
                            res_we   <= 1'b1;
                            res_idx  <= adc_ch;
                            state    <= S_STORE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    S_STORE: begin
                        last_ch <= adc_ch;
                        ch_ptr  <= PTR_W'(adc_ch) + PTR_W'(1);
                        state   <= S_SELECT;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= S_IDLE;
                        adc_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        status = {ST_LAST_W'(last_ch), pending, busy};
    end

endmodule
